// File: rtl/msi_snoop_transmitter_if.sv
// CPU-side and bus-side signal bundle for the MSI snoop transmitter.
// The master modport is the transmitter's view; slave is the environment's view.
interface msi_snoop_transmitter_if #(
    parameter int TAG_W = 4,
    parameter int IDX_W = 2
);
    localparam int AW = TAG_W + IDX_W;

    logic          i_CpuReq;
    logic          i_CpuWrite;
    logic [AW-1:0] i_CpuAddr;
    logic          o_CpuReady;
    logic          o_CpuDone;
    logic          o_BusReq;
    logic          i_BusGrant;
    logic          o_MsgValid;
    logic [1:0]    o_Message;
    logic [AW-1:0] o_MsgAddr;
    logic          o_WriteBack;
    logic [AW-1:0] o_WbAddr;
    logic          i_Abort;
    logic          i_SnoopUpd;
    logic [IDX_W-1:0] i_SnoopIdx;
    logic [1:0]    i_SnoopState;

    modport master (
        input  i_CpuReq, i_CpuWrite, i_CpuAddr, i_BusGrant, i_Abort,
               i_SnoopUpd, i_SnoopIdx, i_SnoopState,
        output o_CpuReady, o_CpuDone, o_BusReq, o_MsgValid, o_Message,
               o_MsgAddr, o_WriteBack, o_WbAddr
    );

    modport slave (
        output i_CpuReq, i_CpuWrite, i_CpuAddr, i_BusGrant, i_Abort,
               i_SnoopUpd, i_SnoopIdx, i_SnoopState,
        input  o_CpuReady, o_CpuDone, o_BusReq, o_MsgValid, o_Message,
               o_MsgAddr, o_WriteBack, o_WbAddr
    );
endinterface

// File: rtl/msi_snoop_transmitter.sv
// MSI requester: CPU lookup in a direct-mapped state/tag array, bus arbitration and miss/invalidate broadcast.
// Optional MSI_TX_STATS_EN adds o_MsgCount, a saturating count of committed broadcasts.
module msi_snoop_transmitter #(
    parameter int NUM_LINES = 4,
    parameter int TAG_W     = 4
) (
    input  logic i_Clk,
    input  logic i_Reset,
    msi_snoop_transmitter_if.master bus
`ifdef MSI_TX_STATS_EN
    ,
    output logic [7:0] o_MsgCount
`endif
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int AW    = TAG_W + IDX_W;

    localparam logic [1:0] ST_I = 2'd0;
    localparam logic [1:0] ST_S = 2'd1;
    localparam logic [1:0] ST_M = 2'd2;

    localparam logic [1:0] MSG_NONE = 2'd0;
    localparam logic [1:0] MSG_RM   = 2'd1;
    localparam logic [1:0] MSG_WM   = 2'd2;
    localparam logic [1:0] MSG_INV  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_ARB    = 3'd2,
        S_WB     = 3'd3,
        S_SEND   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic           r_write;
    logic [AW-1:0]  r_addr;
    logic [1:0]     r_msg;
    logic [1:0]     r_new_st;

    logic [1:0]       w_line_st  [NUM_LINES];
    logic [TAG_W-1:0] w_line_tag [NUM_LINES];

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [1:0]       w_cur_st;
    logic [TAG_W-1:0] w_cur_tag;
    logic             w_hit;
    logic [1:0]       w_lk_msg;
    logic [1:0]       w_lk_st;
    logic             w_victim_dirty;
    logic             w_snoop_hit;
    logic             w_commit;

    assign w_idx     = r_addr[IDX_W-1:0];
    assign w_tag     = r_addr[AW-1:IDX_W];
    assign w_cur_st  = w_line_st[w_idx];
    assign w_cur_tag = w_line_tag[w_idx];
    assign w_hit     = (w_cur_tag == w_tag) && ((w_cur_st == ST_S) || (w_cur_st == ST_M));

    assign w_victim_dirty = (w_cur_st == ST_M) && (w_cur_tag != w_tag);
    assign w_snoop_hit    = bus.i_SnoopUpd && (bus.i_SnoopIdx == w_idx);
    assign w_commit       = (r_state == S_SEND) && !bus.i_Abort;

    // Lookup decision: misses always broadcast; only a Shared write hit needs an invalidate.
    always_comb begin
        w_lk_msg = MSG_NONE;
        w_lk_st  = w_cur_st;
        if (!w_hit) begin
            w_lk_msg = r_write ? MSG_WM : MSG_RM;
            w_lk_st  = r_write ? ST_M : ST_S;
        end else if ((w_cur_st == ST_S) && r_write) begin
            w_lk_msg = MSG_INV;
            w_lk_st  = ST_M;
        end
    end

    // A local commit to a line outranks a snoop update in the same cycle.
    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
        logic [1:0]       r_st;
        logic [TAG_W-1:0] r_tag;

        always_ff @(posedge i_Clk or posedge i_Reset) begin
            if (i_Reset) begin
                r_st  <= ST_I;
                r_tag <= '0;
            end else if (w_commit && (w_idx == IDX_W'(gi))) begin
                r_st  <= r_new_st;
                r_tag <= w_tag;
            end else if (bus.i_SnoopUpd && (bus.i_SnoopIdx == IDX_W'(gi))) begin
                r_st  <= bus.i_SnoopState;
            end
        end

        assign w_line_st[gi]  = r_st;
        assign w_line_tag[gi] = r_tag;
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (bus.i_CpuReq) w_next_state = S_LOOKUP;
            S_LOOKUP: w_next_state = (w_lk_msg == MSG_NONE) ? S_DONE : S_ARB;
            S_ARB: begin
                if (w_snoop_hit)         w_next_state = S_LOOKUP;
                else if (bus.i_BusGrant) w_next_state = w_victim_dirty ? S_WB : S_SEND;
            end
            S_WB:     w_next_state = w_snoop_hit ? S_LOOKUP : S_SEND;
            S_SEND:   w_next_state = bus.i_Abort ? S_ARB : S_DONE;
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.o_CpuReady  = 1'b0;
        bus.o_CpuDone   = 1'b0;
        bus.o_BusReq    = 1'b0;
        bus.o_WriteBack = 1'b0;
        bus.o_WbAddr    = '0;
        bus.o_MsgValid  = 1'b0;
        bus.o_Message   = MSG_NONE;
        bus.o_MsgAddr   = '0;
        case (r_state)
            S_IDLE: bus.o_CpuReady = 1'b1;
            S_ARB:  bus.o_BusReq   = 1'b1;
            S_WB: begin
                bus.o_WriteBack = 1'b1;
                bus.o_WbAddr    = {w_cur_tag, w_idx};
            end
            S_SEND: begin
                bus.o_MsgValid = 1'b1;
                bus.o_Message  = r_msg;
                bus.o_MsgAddr  = r_addr;
            end
            S_DONE: bus.o_CpuDone = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_msg    <= MSG_NONE;
            r_new_st <= ST_I;
        end else begin
            if ((r_state == S_IDLE) && bus.i_CpuReq) begin
                r_write <= bus.i_CpuWrite;
                r_addr  <= bus.i_CpuAddr;
            end
            if (r_state == S_LOOKUP) begin
                r_msg    <= w_lk_msg;
                r_new_st <= w_lk_st;
            end
        end
    end

`ifdef MSI_TX_STATS_EN
    logic [7:0] r_msg_cnt;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_msg_cnt <= 8'd0;
        end else if (w_commit && (r_msg_cnt != 8'hFF)) begin
            r_msg_cnt <= r_msg_cnt + 8'd1;
        end
    end

    assign o_MsgCount = r_msg_cnt;
`endif
endmodule
